// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and control bundle for the SHA-256 round sequencer.
// SHA256_MULTIBLOCK_EN adds the BLKWAIT state used between chained message blocks.
package sha256_pkg;

   localparam int NROUNDS_C = 64;
   localparam int NMSG_C    = 16;
   localparam int K_WORD_W  = 32;
   localparam int K_BUS_W   = 2048;
   localparam int CNT_W     = 6;

`ifdef SHA256_MULTIBLOCK_EN
   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE, BLKWAIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
`endif

   typedef struct packed {
      logic load_init;
      logic round_en;
      logic w_sel;
      logic sched_en;
      logic final_add;
      logic done;
   } ctrl_t;

endpackage

// File: rtl/sha256_k_sel.sv
// Combinational 64:1 round-constant mux; word 0 sits in the top 32 bits of the K bus.
module sha256_k_sel
   import sha256_pkg::*;
(
   input  logic [CNT_W-1:0]    count,
   input  logic [K_BUS_W-1:0]  K,
   output logic [K_WORD_W-1:0] Kout
);

   logic [K_WORD_W-1:0] words [NROUNDS_C];

   for (genvar i = 0; i < NROUNDS_C; i++) begin : g_word
      assign words[i] = K[K_BUS_W-1-K_WORD_W*i -: K_WORD_W];
   end

   assign Kout = words[count];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: INIT, 64 rounds, FINAL add, DONE pulse.
// SHA256_MULTIBLOCK_EN adds last_block/next_blk to chain blocks without re-initialising H.
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int NROUNDS = NROUNDS_C,
   parameter int NMSG    = NMSG_C
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
`ifdef SHA256_MULTIBLOCK_EN
   input  logic                last_block,
   output logic                next_blk,
`endif
   input  logic [K_BUS_W-1:0]  K,
   output logic                ready,
   output logic                busy,
   output logic [CNT_W-1:0]    count,
   output logic [K_WORD_W-1:0] Kout,
   output logic                load_init,
   output logic                round_en,
   output logic                w_sel,
   output logic                sched_en,
   output logic                final_add,
   output logic                done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NROUNDS-1);
   localparam logic [CNT_W-1:0] NMSG_CNT = CNT_W'(NMSG);

   state_t           state, state_nx;
   logic [CNT_W-1:0] count_nx;
   ctrl_t            ctrl;

`ifdef SHA256_MULTIBLOCK_EN
   logic last_q, nb_q;

   // last_block travels with the start that launched the block
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
         nb_q   <= 1'b0;
      end else begin
         if (start && (state == IDLE || state == BLKWAIT))
            last_q <= last_block;
         nb_q <= (state == FINAL) && !last_q;
      end
   end

   assign next_blk = nb_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      ctrl     = '0;
      case (state)
         IDLE:  if (start) state_nx = INIT;
         INIT: begin
            ctrl.load_init = 1'b1;
            count_nx       = '0;
            state_nx       = ROUND;
         end
         ROUND: begin
            ctrl.round_en = 1'b1;
            ctrl.sched_en = 1'b1;
            ctrl.w_sel    = (count < NMSG_CNT);
            if (count == LAST_CNT) begin
               count_nx = '0;
               state_nx = FINAL;
            end else begin
               count_nx = count + CNT_W'(1);
            end
         end
         FINAL: begin
            ctrl.final_add = 1'b1;
`ifdef SHA256_MULTIBLOCK_EN
            state_nx = last_q ? DONE : BLKWAIT;
`else
            state_nx = DONE;
`endif
         end
         DONE: begin
            ctrl.done = 1'b1;
            state_nx  = IDLE;
         end
`ifdef SHA256_MULTIBLOCK_EN
         BLKWAIT: if (start) state_nx = INIT;
`endif
         default: state_nx = IDLE;
      endcase
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == INIT) || (state == ROUND) || (state == FINAL);
   assign load_init = ctrl.load_init;
   assign round_en  = ctrl.round_en;
   assign w_sel     = ctrl.w_sel;
   assign sched_en  = ctrl.sched_en;
   assign final_add = ctrl.final_add;
   assign done      = ctrl.done;

   sha256_k_sel u_k_sel (
      .count (count),
      .K     (K),
      .Kout  (Kout)
   );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: per-cycle scoreboard plus K/w_sel table and corner sequences.
module tb_sha256_round_ctrl;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2047:0] K;
   logic          ready, busy, load_init, round_en, w_sel, sched_en, final_add, done;
   logic [5:0]    count;
   logic [31:0]   Kout;
`ifdef SHA256_MULTIBLOCK_EN
   logic          last_block = 1'b1;
   logic          next_blk;
`endif

   sha256_round_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef SHA256_MULTIBLOCK_EN
      .last_block(last_block), .next_blk(next_blk),
`endif
      .K(K), .ready(ready), .busy(busy), .count(count), .Kout(Kout),
      .load_init(load_init), .round_en(round_en), .w_sel(w_sel),
      .sched_en(sched_en), .final_add(final_add), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic ready, busy, load_init, round_en, w_sel, sched_en, final_add, done;
      logic [5:0]  count;
      logic [31:0] kout;
   } obs_t;

   typedef struct {
      int          cnt;
      logic [31:0] kout;
      logic        wsel;
   } kv_t;

   logic [31:0] kstd [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   kv_t  ktab [6];
   int   khit [6];
   obs_t sb [$];
   int   errors = 0;
   int   checks = 0;

   function automatic obs_t cur();
      obs_t o;
      o.ready = ready; o.busy = busy; o.load_init = load_init; o.round_en = round_en;
      o.w_sel = w_sel; o.sched_en = sched_en; o.final_add = final_add; o.done = done;
      o.count = count; o.kout = Kout;
      return o;
   endfunction

   // Expected outputs n cycles after the accepting edge; n=68 is the IDLE cycle afterwards.
   function automatic obs_t exp_at(int n);
      obs_t o = '0;
      if (n == 1) begin
         o.busy = 1'b1; o.load_init = 1'b1;
      end else if (n >= 2 && n <= 65) begin
         o.busy = 1'b1; o.round_en = 1'b1; o.sched_en = 1'b1;
         o.count = 6'(n - 2);
         o.w_sel = (n - 2) < 16;
      end else if (n == 66) begin
         o.busy = 1'b1; o.final_add = 1'b1;
      end else if (n == 67) begin
         o.done = 1'b1;
      end else begin
         o.ready = 1'b1;
      end
      o.kout = kstd[o.count];
      return o;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Launch nb blocks; hold keeps start high throughout (back-to-back).
   task automatic run_blocks(input int nb, input bit hold);
      obs_t a, e;
      int   wsel_n = 0, done_n = 0, init_n = 0;
      for (int b = 0; b < nb; b++)
         for (int n = 1; n <= 68; n++) sb.push_back(exp_at(n));
      start = 1'b1;
      for (int c = 0; c < nb * 68; c++) begin
         @(negedge clk);
         a = cur();
         e = sb.pop_front();
         check($sformatf("cycle%0d", c + 1), 64'(a), 64'(e));
         wsel_n += int'(w_sel);
         done_n += int'(done);
         init_n += int'(load_init);
         if (round_en)
            for (int t = 0; t < 6; t++)
               if (int'(count) == ktab[t].cnt) begin
                  khit[t]++;
                  check($sformatf("kout@%0d", ktab[t].cnt), 64'(Kout), 64'(ktab[t].kout));
                  check($sformatf("wsel@%0d", ktab[t].cnt), 64'(w_sel), 64'(ktab[t].wsel));
               end
         if (!hold || c == nb * 68 - 1) start = 1'b0;
      end
      check("wsel_cycles", 64'(wsel_n), 64'(16 * nb));
      check("done_pulses", 64'(done_n), 64'(nb));
      check("init_pulses", 64'(init_n), 64'(nb));
   endtask

   initial begin
      obs_t idle_o;
      bit   found;
      ktab[0] = '{0,  32'h428a2f98, 1'b1};
      ktab[1] = '{1,  32'h71374491, 1'b1};
      ktab[2] = '{6,  32'h923f82a4, 1'b1};
      ktab[3] = '{15, 32'hc19bf174, 1'b1};
      ktab[4] = '{16, 32'he49b69c1, 1'b0};
      ktab[5] = '{63, 32'hc67178f2, 1'b0};
      for (int i = 0; i < 64; i++) K[2047 - 32*i -: 32] = kstd[i];
      idle_o = exp_at(0);

      #3;
      check("reset_state", 64'(cur()), 64'(idle_o));
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 64'(cur()), 64'(idle_o));

      // single block, then two back-to-back with start held high
      for (int t = 0; t < 6; t++) khit[t] = 0;
      run_blocks(1, 1'b0);
      for (int t = 0; t < 6; t++) check($sformatf("khit%0d", t), 64'(khit[t]), 64'd1);
      run_blocks(2, 1'b1);

      // abort at count 40
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (round_en && count == 6'd40) found = 1'b1;
      end
      check("reach_count40", 64'(found), 64'd1);
      #1 reset = 1'b1;
      #1 check("async_reset", 64'(cur()), 64'(idle_o));
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("idle_after_abort", 64'(cur()), 64'(idle_o));
      run_blocks(1, 1'b0);

`ifdef SHA256_MULTIBLOCK_EN
      begin
         int nb_n, dn_n, li_n;
         last_block = 1'b0; start = 1'b1;
         @(negedge clk); start = 1'b0;
         nb_n = 0; dn_n = 0; li_n = int'(load_init);
         for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            nb_n += int'(next_blk); dn_n += int'(done); li_n += int'(load_init);
         end
         check("blk1_next_blk", 64'(nb_n), 64'd1);
         check("blk1_done", 64'(dn_n), 64'd0);
         check("blk1_load_init", 64'(li_n), 64'd1);
         check("blk1_waiting", 64'({ready, busy}), 64'd0);
         last_block = 1'b1; start = 1'b1;
         @(negedge clk); start = 1'b0;
         nb_n = 0; dn_n = 0; li_n = int'(load_init);
         for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            nb_n += int'(next_blk); dn_n += int'(done); li_n += int'(load_init);
         end
         check("blk2_next_blk", 64'(nb_n), 64'd0);
         check("blk2_done", 64'(dn_n), 64'd1);
         check("blk2_load_init", 64'(li_n), 64'd1);
         check("blk2_ready", 64'(ready), 64'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
